mega_mul_seq: RTL
=================

Name: mega_mul_seq

Overview:
Multi-cycle multiply sequencer for the MEGA/XMEGA core: executes MUL, MULS, MULSU, FMUL, FMULS and FMULSU using an iterative shift-add engine instead of a DSP multiplier. It is used on platforms or core variants without a hardware multiplier. The decoder/execute stage hands it operands through a req/ready handshake and stalls until done. On done it returns the 16-bit product for R1:R0 and an updated SREG.

Parameters:
BITS_PER_CYCLE, 1, multiplier bits retired per CALC cycle; legal values 1, 2, 4; CALC lasts 8/BITS_PER_CYCLE cycles.
PLATFORM, "XILINX", target family; no functional effect.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-high.
req  in  1  start request; accepted only on a rising edge where ready=1.
op  in  3  operation: 0 MUL, 1 MULS, 2 MULSU, 4 FMUL, 5 FMULS, 6 FMULSU; 3 and 7 are reserved.
rd  in  8  multiplicand (Rd); signed for MULS/MULSU/FMULS/FMULSU.
rr  in  8  multiplier (Rr); signed for MULS/FMULS only.
sreg_in  in  8  SREG at issue.
ready  out  1  block can accept req (IDLE or DONE state).
busy  out  1  operation in progress (CALC or FIX state).
done  out  1  one-cycle pulse; R and sreg_out are valid.
R  out  16  product; held until the next completion.
sreg_out  out  8  SREG result; held until the next completion.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, R=0, sreg_out=0, done=0, busy=0, ready=1. Reset mid-operation aborts the operation with no partial write-back.
- States:
  - IDLE: ready=1. If req=1, capture op, rd, rr and sreg_in, then go to CALC.
  - CALC: busy=1. Retire BITS_PER_CYCLE bits per cycle. Go to FIX when the iteration counter reaches 8/BITS_PER_CYCLE-1.
  - FIX: busy=1. Register R and sreg_out, then go to DONE.
  - DONE: done=1, ready=1. If req=1, accept a new operation as in IDLE and go to CALC; otherwise go to IDLE.
- Timing: a req accepted at edge N gives R and sreg_out updated at edge N+8/BPC+1, with done high for the following cycle. With BPC=1, done is high between edges N+9 and N+10.
- req while busy=1 is ignored; there is no queueing. Captured operands are immune to input changes after acceptance.
- Arithmetic is sign-magnitude:
  - Signedness: a_neg = rd[7] for signed-a ops; b_neg = rr[7] for MULS/FMULS.
  - Operand magnitudes are 8-bit unsigned. |-128| = 0x80 is handled without overflow.
  - Accumulate the 16-bit unsigned product.
  - In FIX, two's-complement negate when a_neg^b_neg, giving the 16-bit product P.
- Flags (C=bit0, Z=bit1; all other bits equal captured sreg_in):
  - MUL/MULS/MULSU: R=P, C=P[15], Z=(R==0).
  - FMUL/FMULS/FMULSU: R=P<<1, C=P[15], Z=(R==0) evaluated on the shifted R.
- Reserved op: runs the full latency, then R=0 and sreg_out=captured sreg_in unchanged.
- busy and ready are never both 1; done is never high while busy=1.

Decomposition:
- mega-def.v gets the op codes MEGA_MUL_OP_MUL..MEGA_MUL_OP_FMULSU and reuses XMEGA_FLAG_C/XMEGA_FLAG_Z; state encodings stay local.
- Sub-module mega_mul_step: combinational step taking {acc, multiplier bits, multiplicand} and producing the next acc. It is instantiated once, and its width depends on BITS_PER_CYCLE.

Test Plan:
- MUL rd=0xFF rr=0xFF, BPC=1 -> done exactly 9 edges after accept; R=0xFE01, C=1, Z=0, other SREG bits = sreg_in (0xA4 -> 0xA5).
- MULS 0x80*0x80 -> R=0x4000, C=0. MULSU rd=0x80 rr=0xFF -> R=0x8080, C=1. MULS 0xFF*0x01 -> R=0xFFFF, C=1.
- FMUL 0x80*0x80 -> R=0x8000, C=0, Z=0. FMULS 0x80*0x80 -> R=0x8000, C=0. FMULSU 0xC0*0x80 -> P=0xE000, R=0xC000, C=1.
- MUL 0x00*0x55 -> R=0, Z=1, C=0. Reserved op 3 -> R=0, sreg_out=sreg_in.
- Back-to-back req held high -> second op accepted in the DONE cycle. req pulses while busy -> ignored, result unaffected. Inputs changed mid-op -> result unaffected.
- Assert rst at CALC cycle 4 -> immediately IDLE, R=0, sreg_out=0, no done. Then a fresh MUL 0x12*0x34 -> R=0x03A8.
- Repeat tests 1-3 with BPC=2 and BPC=4 -> identical results; done at 5 and 3 edges after accept respectively.

Source files
------------

// File: rtl/mega_mul_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mega_mul_seq_pkg                                                |
// | Purpose  : Shared op codes, SREG flag positions and op-decode helpers for  |
// |            the iterative MEGA/XMEGA multiply sequencer.                    |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mega_mul_seq_pkg;

  typedef logic [2:0] mul_op_t;

  localparam mul_op_t MEGA_MUL_OP_MUL    = 3'd0;
  localparam mul_op_t MEGA_MUL_OP_MULS   = 3'd1;
  localparam mul_op_t MEGA_MUL_OP_MULSU  = 3'd2;
  localparam mul_op_t MEGA_MUL_OP_FMUL   = 3'd4;
  localparam mul_op_t MEGA_MUL_OP_FMULS  = 3'd5;
  localparam mul_op_t MEGA_MUL_OP_FMULSU = 3'd6;

  localparam int XMEGA_FLAG_C = 0;
  localparam int XMEGA_FLAG_Z = 1;

  // Rd is signed for every op except the plain unsigned ones.
  function automatic logic op_a_signed(input mul_op_t op);
    return (op == MEGA_MUL_OP_MULS)  || (op == MEGA_MUL_OP_MULSU) ||
           (op == MEGA_MUL_OP_FMULS) || (op == MEGA_MUL_OP_FMULSU);
  endfunction

  // Rr is signed only for the fully signed ops.
  function automatic logic op_b_signed(input mul_op_t op);
    return (op == MEGA_MUL_OP_MULS) || (op == MEGA_MUL_OP_FMULS);
  endfunction

  function automatic logic op_is_frac(input mul_op_t op);
    return (op == MEGA_MUL_OP_FMUL) || (op == MEGA_MUL_OP_FMULS) ||
           (op == MEGA_MUL_OP_FMULSU);
  endfunction

  function automatic logic op_is_reserved(input mul_op_t op);
    return !((op == MEGA_MUL_OP_MUL)  || (op == MEGA_MUL_OP_MULS)  ||
             (op == MEGA_MUL_OP_MULSU) || op_is_frac(op));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mega_mul_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mega_mul_seq_if                                                 |
// | Purpose  : Issue/complete bus between the execute stage and the multiply   |
// |            sequencer.                                                      |
// | Ports    : master drives req/op/rd/rr/sreg_in and observes status/results; |
// |            slave (the sequencer) is the mirror image.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface mega_mul_seq_if;

  logic        req;
  logic [2:0]  op;
  logic [7:0]  rd;
  logic [7:0]  rr;
  logic [7:0]  sreg_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] R;
  logic [7:0]  sreg_out;

  modport master (
    output req, op, rd, rr, sreg_in,
    input  ready, busy, done, R, sreg_out
  );

  modport slave (
    input  req, op, rd, rr, sreg_in,
    output ready, busy, done, R, sreg_out
  );

endinterface
`default_nettype wire

// File: rtl/mega_mul_seq_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mega_mul_step                                                   |
// | Purpose  : One combinational shift-add iteration: adds the pre-aligned     |
// |            multiplicand, shifted by j, for every set multiplier bit j.     |
// | Ports    : i_acc   - running 16-bit accumulator                            |
// |            i_bits  - BITS_PER_CYCLE multiplier bits retired this cycle     |
// |            i_mcand - multiplicand already aligned to the current bit pos.  |
// |            o_acc   - next accumulator value                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mega_mul_step #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  wire logic [15:0]               i_acc,
  input  wire logic [BITS_PER_CYCLE-1:0] i_bits,
  input  wire logic [15:0]               i_mcand,
  output logic      [15:0]               o_acc
);

  logic [15:0] w_pp [BITS_PER_CYCLE];

  for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_pp
    assign w_pp[j] = i_bits[j] ? (i_mcand << j) : 16'h0000;
  end

  // 8x8 magnitudes never exceed 0xFE01, so 16 bits cannot overflow.
  always_comb begin
    o_acc = i_acc;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      o_acc = o_acc + w_pp[k];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mega_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mega_mul_seq                                                    |
// | Purpose  : Iterative sign-magnitude multiply sequencer for MUL/MULS/MULSU/ |
// |            FMUL/FMULS/FMULSU on cores without a hardware multiplier.       |
// | Ports    : clk - core clock, rst - asynchronous active-high reset          |
// |            bus - slave side of mega_mul_seq_if (req/op/rd/rr/sreg_in in,   |
// |                  ready/busy/done/R/sreg_out out)                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mega_mul_seq
  import mega_mul_seq_pkg::*;
#(
  parameter int    BITS_PER_CYCLE = 1,
  parameter string PLATFORM       = "XILINX"
) (
  input wire logic      clk,
  input wire logic      rst,
  mega_mul_seq_if.slave bus
);

  localparam int         c_STEPS = 8 / BITS_PER_CYCLE;
  localparam logic [2:0] c_LAST  = 3'(c_STEPS - 1);

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
      (PLATFORM == "")) begin : g_param_check
    $error("mega_mul_seq: BITS_PER_CYCLE must be 1, 2 or 4 and PLATFORM non-empty");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_last;
  logic        w_ready;
  logic        w_busy;
  logic        w_done;

  mul_op_t     r_op;
  logic [7:0]  r_sreg;
  logic        r_neg;
  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;
  logic [2:0]  r_cnt;
  logic [15:0] r_R;
  logic [7:0]  r_sreg_out;

  logic        w_a_neg;
  logic        w_b_neg;
  logic [7:0]  w_a_mag;
  logic [7:0]  w_b_mag;
  logic [15:0] w_step_acc;
  logic [15:0] w_p;
  logic [15:0] w_res;
  logic [7:0]  w_sreg_res;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_last = (r_cnt == c_LAST);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_ready  = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.req) begin
          w_accept = 1'b1;
          w_next   = S_CALC;
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_busy = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_ready = 1'b1;
        w_done  = 1'b1;
        if (bus.req) begin
          w_accept = 1'b1;
          w_next   = S_CALC;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ operand decode
  // Magnitudes are taken in 8 bits: 0 - 0x80 wraps back to 0x80, which is
  // exactly |-128|, so no ninth bit is needed.
  assign w_a_neg = op_a_signed(bus.op) & bus.rd[7];
  assign w_b_neg = op_b_signed(bus.op) & bus.rr[7];
  assign w_a_mag = w_a_neg ? (8'h00 - bus.rd) : bus.rd;
  assign w_b_mag = w_b_neg ? (8'h00 - bus.rr) : bus.rr;

  mega_mul_step #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .i_acc   (r_acc),
    .i_bits  (r_mplier[BITS_PER_CYCLE-1:0]),
    .i_mcand (r_mcand),
    .o_acc   (w_step_acc)
  );

  // ------------------------------------------------------ result shaping
  assign w_p = r_neg ? (16'h0000 - r_acc) : r_acc;

  always_comb begin
    w_res      = 16'h0000;
    w_sreg_res = r_sreg;
    if (!op_is_reserved(r_op)) begin
      w_res                    = op_is_frac(r_op) ? {w_p[14:0], 1'b0} : w_p;
      // C always reflects the unshifted product's MSB, Z the written value.
      w_sreg_res[XMEGA_FLAG_C] = w_p[15];
      w_sreg_res[XMEGA_FLAG_Z] = (w_res == 16'h0000);
    end
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= '0;
      r_sreg     <= '0;
      r_neg      <= 1'b0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_cnt      <= '0;
      r_R        <= '0;
      r_sreg_out <= '0;
    end else if (w_accept) begin
      r_op     <= bus.op;
      r_sreg   <= bus.sreg_in;
      r_neg    <= w_a_neg ^ w_b_neg;
      r_acc    <= '0;
      r_mcand  <= {8'h00, w_a_mag};
      r_mplier <= w_b_mag;
      r_cnt    <= '0;
    end else if (r_state == S_CALC) begin
      r_acc    <= w_step_acc;
      r_mcand  <= r_mcand << BITS_PER_CYCLE;
      r_mplier <= r_mplier >> BITS_PER_CYCLE;
      r_cnt    <= r_cnt + 3'd1;
    end else if (r_state == S_FIX) begin
      r_R        <= w_res;
      r_sreg_out <= w_sreg_res;
    end
  end

  assign bus.ready    = w_ready;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.R        = r_R;
  assign bus.sreg_out = r_sreg_out;

endmodule
`default_nettype wire
